// File: rtl/countdown_result_capture.sv
// countdown_result_capture: measures countdown runs on x and queues {y, cycles} records in a small FIFO.
module countdown_result_capture #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic [CNT_W-1:0] res_cycles,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x_prev;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_start, w_push, w_pop, w_full, w_empty, w_wr_en, w_drop;
  logic [WIDTH-1:0] r_y_mem [DEPTH];
  logic [CNT_W-1:0] r_c_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  assign w_start   = (x != '0) && ((r_x_prev == '0) || (x > r_x_prev));
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = !w_empty && res_ready;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    if (r_state == IDLE) begin
      if (w_start) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = CNT_W'(1);
      end
    end else if (x == '0) begin
      w_push      = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      w_cnt_nxt = w_start ? CNT_W'(1) : w_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x_prev <= '0;
      r_state  <= IDLE;
      r_cnt    <= '0;
    end else begin
      r_x_prev <= x;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_y_mem[i] <= '0;
        r_c_mem[i] <= '0;
      end
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_y_mem[r_wr] <= y;
        r_c_mem[r_wr] <= w_cnt_inc;
        r_wr          <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_wr_en && !w_pop) r_count <= r_count + (AW+1)'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign res_valid  = !w_empty;
  assign res_y      = w_empty ? '0 : r_y_mem[r_rd];
  assign res_cycles = w_empty ? '0 : r_c_mem[r_rd];
  assign busy       = (r_state == RUN);
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;
endmodule
